// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: one BRAM port shared by a display reader (strict priority),
// a buffered capture writer and a detector reader (round-robin between the latter two).
module fb_port_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_disp_req,
    input  logic [17:0]                 i_disp_addr,
    output logic [15:0]                 o_disp_rdata,
    output logic                        o_disp_rvalid,
    input  logic                        i_wr_valid,
    input  logic [17:0]                 i_wr_addr,
    input  logic [15:0]                 i_wr_data,
    output logic                        o_wr_ready,
    input  logic                        i_det_req,
    input  logic [17:0]                 i_det_addr,
    output logic                        o_det_gnt,
    output logic [15:0]                 o_det_rdata,
    output logic                        o_det_rvalid,
    output logic [17:0]                 o_bram_addr,
    output logic                        o_bram_we,
    output logic [15:0]                 o_bram_wdata,
    input  logic [15:0]                 i_bram_rdata,
    output logic [$clog2(FIFO_DEPTH):0] o_wr_level,
    output logic                        o_starve_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_entry_t;

    typedef enum logic {
        RR_WRITER   = 1'b0,
        RR_DETECTOR = 1'b1
    } rr_t;

    wr_entry_t     fifo_mem [FIFO_DEPTH];
    wr_entry_t     head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    rr_t           rr_last;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_d;
    logic [17:0]   addr_q;
    logic          disp_tag;
    logic          det_tag;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          disp_gnt;
    logic          wr_gnt;
    logic          det_gnt;

    assign full       = (level == LEVEL_FULL);
    assign empty      = (level == '0);
    assign o_wr_ready = !full;
    assign push       = i_wr_valid && !full;
    assign pop        = wr_gnt;
    assign head       = fifo_mem[rd_ptr];
    assign o_wr_level = level;

    // Grants are forced off while reset is held so the BRAM port is quiet during reset.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        disp_gnt = 1'b0;
        wr_gnt   = 1'b0;
        det_gnt  = 1'b0;
        if (i_rstn) begin
            if (i_disp_req) begin
                disp_gnt = 1'b1;
            end else if (!empty && i_det_req) begin
                if (rr_last == RR_DETECTOR) wr_gnt  = 1'b1;
                else                        det_gnt = 1'b1;
            end else if (!empty) begin
                wr_gnt = 1'b1;
            end else if (i_det_req) begin
                det_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        o_bram_addr  = addr_q;
        o_bram_we    = 1'b0;
        o_bram_wdata = '0;
        if (disp_gnt) begin
            o_bram_addr = i_disp_addr;
        end else if (wr_gnt) begin
            o_bram_addr  = head.addr;
            o_bram_we    = 1'b1;
            o_bram_wdata = head.data;
        end else if (det_gnt) begin
            o_bram_addr = i_det_addr;
        end
    end

    always_comb begin
        if (empty || wr_gnt)              starve_cnt_d = '0;
        else if (starve_cnt == STARVE_MAX) starve_cnt_d = starve_cnt;
        else                               starve_cnt_d = starve_cnt + CW'(1);
    end

    assign o_det_gnt     = det_gnt;
    assign o_disp_rdata  = i_bram_rdata;
    assign o_det_rdata   = i_bram_rdata;
    assign o_disp_rvalid = disp_tag;
    assign o_det_rvalid  = det_tag;

    // NOTE: the entry storage has no reset; the pointers and level alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr] <= {i_wr_addr, i_wr_data};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rr_last      <= RR_DETECTOR;
            starve_cnt   <= '0;
            o_starve_err <= 1'b0;
            addr_q       <= '0;
            disp_tag     <= 1'b0;
            det_tag      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (wr_gnt)       rr_last <= RR_WRITER;
            else if (det_gnt) rr_last <= RR_DETECTOR;
            starve_cnt <= starve_cnt_d;
            if (starve_cnt_d == STARVE_MAX) o_starve_err <= 1'b1;
            addr_q   <= o_bram_addr;
            disp_tag <= disp_gnt;
            det_tag  <= det_gnt;
        end
    end

endmodule
